// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port synchronous memory between the fetch
//               port and the load/store port (IDLE -> ISSUE -> RESP sequence).
//               Optional macro ARB_RR_EN selects round-robin arbitration;
//               default build uses fixed D-over-IF priority.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_sel,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_if,
  output logic                stallreq_d
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;   // 0 = IF, 1 = D
  logic   we_q, we_d;     // store flag captured at grant time
  logic   pick;

`ifdef ARB_RR_EN
  logic last_q, last_d;   // port served most recently, 0 = IF, 1 = D

  always_comb begin
    pick = d_req;
    if (d_req && if_req) begin
      pick = ~last_q;
    end
  end
`else
  always_comb begin
    pick = d_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d = ST_ISSUE;
          gnt_d   = pick;
          we_d    = pick & d_we;
`ifdef ARB_RR_EN
          last_d  = pick;
`endif
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs decode from the registered state only, so an asynchronous reset
  // clears the memory strobes in the same cycle.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_sel   = '0;
    if_ready  = 1'b0;
    if_rdata  = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    case (state_q)
      ST_ISSUE: begin
        mem_ce = 1'b1;
        if (gnt_q) begin
          mem_we    = we_q;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_sel   = d_sel;
        end else begin
          mem_addr  = if_addr;
          mem_sel   = '1;
        end
      end
      ST_RESP: begin
        if (gnt_q) begin
          d_ready = 1'b1;
          d_rdata = we_q ? '0 : mem_rdata;
        end else begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign stallreq_if = if_req & ~if_ready;
  assign stallreq_d  = d_req & ~d_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (shadow memory + grant-order rules).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata = '0;
  logic        stallreq_if, stallreq_d;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_dready = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .stallreq_if(stallreq_if), .stallreq_d(stallreq_d)
  );

  // Single-port synchronous memory: 256 words, byte-enabled writes.
  logic [31:0] mem [0:255] = '{default: '0};
  logic [31:0] wmask;
  assign wmask = {{8{mem_sel[3]}}, {8{mem_sel[2]}}, {8{mem_sel[1]}}, {8{mem_sel[0]}}};

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~wmask) | (mem_wdata & wmask);
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_ce && mem_we) n_writes++;
    if (d_ready) n_dready++;
  end

  // Reference model state
  logic [31:0] ref_mem [0:255] = '{default: '0};
`ifdef ARB_RR_EN
  logic ref_last = 1'b0;
`endif

  task automatic apply_reset;
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef ARB_RR_EN
    ref_last = 1'b0;
`endif
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel; d_req = 1'b1;
    lat = -1; rdata = '0;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (d_ready) begin lat = c; rdata = d_rdata; end
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_ce, mem_we, if_ready, d_ready, stallreq_if, stallreq_d} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {mem_ce, mem_we, if_ready, d_ready, stallreq_if, stallreq_d});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, mem_sel, if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0",
                         {mem_addr, mem_wdata, mem_sel, if_rdata, d_rdata});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch;
    logic [31:0] rd; int lat;
    d_access(1'b1, 32'h10, 32'h24020005, 4'hF, rd, lat);
    ref_mem[4] = 32'h24020005;
    if_addr = 32'h10; if_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stallreq_if, mem_ce} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_c0: got stall/ce %b expected 10", {stallreq_if, mem_ce});
    end
    @(negedge clk);
    n_tests++;
    if ({stallreq_if, mem_ce, mem_we, mem_sel, mem_addr} !== {3'b110, 4'hF, 32'h10}) begin
      n_fail++; $display("FAIL fetch_c1: got %h expected %h",
                         {stallreq_if, mem_ce, mem_we, mem_sel, mem_addr}, {3'b110, 4'hF, 32'h10});
    end
    @(negedge clk);
    n_tests++;
    if ({if_ready, stallreq_if, if_rdata} !== {2'b10, 32'h24020005}) begin
      n_fail++; $display("FAIL fetch_c2: got rdy %b stall %b data %h expected 1 0 24020005",
                         if_ready, stallreq_if, if_rdata);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_ready !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse: got if_ready %b expected 0", if_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; int lat; int w0;
    w0 = n_writes;
    d_access(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, rd, lat);
    ref_mem[16] = 32'hDEADBEEF;
    n_tests++;
    if (lat !== 2 || rd !== 32'h0 || n_writes - w0 !== 1) begin
      n_fail++; $display("FAIL store: got lat %0d rdata %h writes %0d expected 2 0 1",
                         lat, rd, n_writes - w0);
    end
    d_access(1'b0, 32'h40, 32'h0, 4'h0, rd, lat);
    n_tests++;
    if (lat !== 2 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load: got lat %0d rdata %h expected 2 deadbeef", lat, rd);
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; int lat;
    d_access(1'b1, 32'h50, 32'h11223344, 4'hF, rd, lat);
    d_access(1'b1, 32'h50, 32'h0000AB00, 4'h2, rd, lat);
    d_access(1'b0, 32'h50, 32'h0, 4'h0, rd, lat);
    ref_mem[20] = 32'h1122AB44;
    n_tests++;
    if (rd !== 32'h1122AB44) begin
      n_fail++; $display("FAIL byte_store: got %h expected 1122ab44", rd);
    end
  endtask

  task automatic test_priority;
    int d_cyc[2]; int if_cyc[2]; int dn; int ifn;
    int exp_d0, exp_d1, exp_i0, exp_i1;
    apply_reset;
    d_cyc = '{-1, -1}; if_cyc = '{-1, -1}; dn = 0; ifn = 0;
    if_addr = 32'h10; d_addr = 32'h40; d_we = 1'b0; d_sel = 4'h0;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_ready && dn < 2) begin d_cyc[dn] = c; dn++; end
      if (if_ready && ifn < 2) begin if_cyc[ifn] = c; ifn++; end
      @(posedge clk); #1;
      if (dn == 2) d_req = 1'b0;
      if (ifn == 2) if_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef ARB_RR_EN
    exp_d0 = 2; exp_i0 = 5; exp_d1 = 8; exp_i1 = 11;
    ref_last = 1'b0;
`else
    exp_d0 = 2; exp_d1 = 5; exp_i0 = 8; exp_i1 = 11;
`endif
    n_tests++;
    if (d_cyc[0] !== exp_d0 || d_cyc[1] !== exp_d1) begin
      n_fail++; $display("FAIL prio_d: got cycles %0d,%0d expected %0d,%0d",
                         d_cyc[0], d_cyc[1], exp_d0, exp_d1);
    end
    n_tests++;
    if (if_cyc[0] !== exp_i0 || if_cyc[1] !== exp_i1) begin
      n_fail++; $display("FAIL prio_if: got cycles %0d,%0d expected %0d,%0d",
                         if_cyc[0], if_cyc[1], exp_i0, exp_i1);
    end
  endtask

  task automatic test_reset_mid_issue;
    logic [31:0] rd; int lat; int w0; int r0;
    d_access(1'b1, 32'h80, 32'h5A5A5A5A, 4'hF, rd, lat);
    ref_mem[32] = 32'h5A5A5A5A;
    d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_sel = 4'hF; d_req = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({mem_ce, mem_we} !== 2'b11) begin
      n_fail++; $display("FAIL rst_issue_pre: got ce/we %b expected 11", {mem_ce, mem_we});
    end
    w0 = n_writes; r0 = n_dready;
    #1 rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    n_tests++;
    if ({mem_ce, mem_we, if_ready, d_ready, stallreq_if, stallreq_d, mem_addr, mem_wdata,
         mem_sel, if_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_issue_outs: got ce %b we %b rdy %b%b expected all 0",
                         mem_ce, mem_we, if_ready, d_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (mem[32] !== 32'h5A5A5A5A || n_writes != w0 || n_dready != r0) begin
      n_fail++; $display("FAIL rst_issue_nocommit: got word %h writes %0d readies %0d expected 5a5a5a5a 0 0",
                         mem[32], n_writes - w0, n_dready - r0);
    end
`ifdef ARB_RR_EN
    ref_last = 1'b0;
`endif
    d_access(1'b0, 32'h80, 32'h0, 4'h0, rd, lat);
    n_tests++;
    if (lat !== 2 || rd !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL rst_issue_restart: got lat %0d data %h expected 2 5a5a5a5a", lat, rd);
    end
`ifdef ARB_RR_EN
    ref_last = 1'b1;
`endif
  endtask

  task automatic test_random;
    logic [1:0]  p;
    logic [31:0] ia, da, wd, m, exp_addr;
    logic        we, first;
    logic [3:0]  sel;
    logic        order [2];
    int          n;
    logic        if_pend, d_pend, exp_if, exp_d, exp_ce, exp_we;
    for (int r = 0; r < 60; r++) begin
      p   = 2'($urandom_range(1, 3));
      ia  = 32'($urandom_range(0, 63)) << 2;
      da  = 32'($urandom_range(0, 63)) << 2;
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      if (p == 2'b11) begin
`ifdef ARB_RR_EN
        first = ~ref_last;
`else
        first = 1'b1;
`endif
        order[0] = first; order[1] = ~first; n = 2;
      end else begin
        order[0] = (p == 2'b10); order[1] = 1'b0; n = 1;
      end
`ifdef ARB_RR_EN
      ref_last = order[n-1];
`endif
      if_addr = ia; d_addr = da; d_wdata = wd; d_we = we; d_sel = sel;
      if_req = p[0]; d_req = p[1]; if_pend = p[0]; d_pend = p[1];
      for (int c = 0; c < 3 * n; c++) begin
        exp_if = 1'b0; exp_d = 1'b0; exp_ce = 1'b0; exp_we = 1'b0; exp_addr = '0;
        for (int k = 0; k < n; k++) begin
          if (c == 3 * k + 2) begin
            if (order[k]) exp_d = 1'b1; else exp_if = 1'b1;
          end
          if (c == 3 * k + 1) begin
            exp_ce = 1'b1;
            exp_we = order[k] & we;
            exp_addr = order[k] ? da : ia;
          end
        end
        @(negedge clk);
        n_tests++;
        if ({if_ready, d_ready, mem_ce, mem_we, mem_addr} !== {exp_if, exp_d, exp_ce, exp_we, exp_addr}) begin
          n_fail++; $display("FAIL rand_hs r%0d c%0d: got rdy %b%b ce %b we %b addr %h expected %b%b %b %b %h",
                             r, c, if_ready, d_ready, mem_ce, mem_we, mem_addr,
                             exp_if, exp_d, exp_ce, exp_we, exp_addr);
        end
        n_tests++;
        if ({stallreq_if, stallreq_d} !== {if_pend & ~exp_if, d_pend & ~exp_d}) begin
          n_fail++; $display("FAIL rand_stall r%0d c%0d: got %b%b expected %b%b", r, c,
                             stallreq_if, stallreq_d, if_pend & ~exp_if, d_pend & ~exp_d);
        end
        if (exp_if) begin
          n_tests++;
          if (if_rdata !== ref_mem[ia[9:2]]) begin
            n_fail++; $display("FAIL rand_if_data r%0d: got %h expected %h", r, if_rdata, ref_mem[ia[9:2]]);
          end
        end
        if (exp_d) begin
          n_tests++;
          if (we) begin
            if (d_rdata !== 32'h0) begin
              n_fail++; $display("FAIL rand_store_rdata r%0d: got %h expected 0", r, d_rdata);
            end
            m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            ref_mem[da[9:2]] = (ref_mem[da[9:2]] & ~m) | (wd & m);
          end else if (d_rdata !== ref_mem[da[9:2]]) begin
            n_fail++; $display("FAIL rand_load r%0d: got %h expected %h", r, d_rdata, ref_mem[da[9:2]]);
          end
        end
        @(posedge clk); #1;
        if (exp_if) begin if_req = 1'b0; if_pend = 1'b0; end
        if (exp_d)  begin d_req = 1'b0; d_pend = 1'b0; d_we = 1'b0; end
      end
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    test_store_load;
    test_byte_store;
    test_priority;
    test_reset_mid_issue;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
